// File: rtl/bsg_chip_link_reset_sequencer.sv
// Sequences io / token / core reset bring-up for a masked group of chip links,
// holding each phase for a programmable number of core cycles.
module bsg_chip_link_reset_sequencer #(
    parameter int num_links_p  = 16,
    parameter int wait_width_p = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [num_links_p-1:0]  link_mask_i,
    input  logic [wait_width_p-1:0] wait_cycles_i,
    output logic                    ready_o,
    output logic                    done_o,
    output logic [num_links_p-1:0]  link_io_reset_o,
    output logic [num_links_p-1:0]  link_core_reset_o,
    output logic [num_links_p-1:0]  link_token_reset_o
);

    typedef enum logic [2:0] {
        IDLE,
        ASSERT,
        TKN_ON,
        TKN_OFF,
        IO_REL,
        DONE
    } state_e;

    state_e state_r, state_n;

    logic [num_links_p-1:0]  mask_r, mask_n;
    logic [num_links_p-1:0]  io_r, io_n;
    logic [num_links_p-1:0]  core_r, core_n;
    logic [num_links_p-1:0]  tkn_r, tkn_n;
    logic [wait_width_p-1:0] reload_r, reload_n;
    logic [wait_width_p-1:0] cnt_r, cnt_n;
    logic [wait_width_p-1:0] start_reload;
    logic                    in_phase;
    logic                    phase_end;

    // A requested dwell of zero behaves exactly like a dwell of one.
    assign start_reload = (wait_cycles_i == '0) ? '0
                        : wait_cycles_i - wait_width_p'(1);

    assign in_phase  = (state_r == ASSERT) || (state_r == TKN_ON)
                    || (state_r == TKN_OFF) || (state_r == IO_REL);
    assign phase_end = (cnt_r == '0);

    always_comb begin
        state_n  = state_r;
        mask_n   = mask_r;
        reload_n = reload_r;
        cnt_n    = cnt_r;
        io_n     = io_r;
        core_n   = core_r;
        tkn_n    = tkn_r;

        if (in_phase) begin
            cnt_n = phase_end ? reload_r : cnt_r - wait_width_p'(1);
        end

        case (state_r)
            IDLE, DONE: begin
                if (start_i) begin
                    state_n  = ASSERT;
                    mask_n   = link_mask_i;
                    reload_n = start_reload;
                    cnt_n    = start_reload;
                    io_n     = io_r | link_mask_i;
                    core_n   = core_r | link_mask_i;
                    tkn_n    = tkn_r & ~link_mask_i;
                end
            end
            ASSERT: begin
                if (phase_end) begin
                    state_n = TKN_ON;
                    tkn_n   = tkn_r | mask_r;
                end
            end
            TKN_ON: begin
                if (phase_end) begin
                    state_n = TKN_OFF;
                    tkn_n   = tkn_r & ~mask_r;
                end
            end
            TKN_OFF: begin
                if (phase_end) begin
                    state_n = IO_REL;
                    io_n    = io_r & ~mask_r;
                end
            end
            IO_REL: begin
                if (phase_end) begin
                    state_n = DONE;
                    core_n  = core_r & ~mask_r;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Reset puts every link back into full reset and forgets any sequence in flight.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r  <= IDLE;
            mask_r   <= '0;
            reload_r <= '0;
            cnt_r    <= '0;
            io_r     <= '1;
            core_r   <= '1;
            tkn_r    <= '0;
        end else begin
            state_r  <= state_n;
            mask_r   <= mask_n;
            reload_r <= reload_n;
            cnt_r    <= cnt_n;
            io_r     <= io_n;
            core_r   <= core_n;
            tkn_r    <= tkn_n;
        end
    end

    assign ready_o            = (state_r == IDLE) || (state_r == DONE);
    assign done_o             = (state_r == DONE);
    assign link_io_reset_o    = io_r;
    assign link_core_reset_o  = core_r;
    assign link_token_reset_o = tkn_r;

endmodule

// File: doc/bsg_chip_link_reset_sequencer.md
# bsg_chip_link_reset_sequencer

Single-clock controller that sequences the reset bring-up of a group of `bsg_chip_io_links_ct_fifo` instances (io-side reset, core-side reset, token reset) in the order the link requires, with a programmable dwell between phases. It sits next to the io/mem link arrays and the tag clients in `bsg_chip`. It replaces per-link manual tag pokes with one start command plus a link mask. Links outside the mask keep their current reset state, so individual links can be re-trained without disturbing live ones.

## Interface
- `num_links_p`, 16: number of links controlled.
- `wait_width_p`, 16: width of the dwell-count input and counter.
- `clk_i` in 1: clock. Core clock domain (hb_clk).
- `reset_i` in 1: reset. Synchronous, active-high.
- `start_i` in 1: start a sequence. Honoured only when `ready_o`=1.
- `link_mask_i` in `num_links_p`: links to sequence. Latched with `start_i`.
- `wait_cycles_i` in `wait_width_p`: dwell per phase. Latched with `start_i`. 0 is treated as 1.
- `ready_o` out 1: accepting `start_i` (state IDLE or DONE).
- `done_o` out 1: high in DONE. Last sequence complete.
- `link_io_reset_o` out `num_links_p`: per-link io-side reset.
- `link_core_reset_o` out `num_links_p`: per-link core-side reset.
- `link_token_reset_o` out `num_links_p`: per-link token reset.

## Operation
- States: IDLE, ASSERT, TKN_ON, TKN_OFF, IO_REL, DONE.
- Latched dwell: W = max(`wait_cycles_i`, 1).
- IDLE / DONE:
  - `ready_o`=1.
  - `start_i`=1 latches the mask into M and loads the counter with W-1.
  - Next state: ASSERT.
- ASSERT: for links in M, io=1, core=1, tkn=0. Stay W cycles, then go to TKN_ON.
- TKN_ON: for links in M, tkn=1 (io and core still 1). W cycles, then TKN_OFF.
- TKN_OFF: for links in M, tkn=0. W cycles, then IO_REL.
- IO_REL: for links in M, io=0 (core still 1). W cycles, then DONE.
- Entering DONE: for links in M, core=0.
- Counter behaviour:
  - Reloads to W-1 on every phase transition.
  - Decrements each cycle; the phase advances when it reads 0.
  - It never wraps; a width of `wait_width_p` is sufficient.
- Links not in M: all three reset bits hold their previous value in every state.
- `start_i` outside IDLE/DONE is ignored: no latch, no effect on the sequence in flight.
- M = 0: the FSM still walks all phases with identical timing, and no output bit changes.
- All outputs come straight from per-link registers or state decode. No combinational path from inputs to outputs.

## Timing
- After `reset_i` (synchronous, on the clock edge):
  - state=IDLE, `ready_o`=1, `done_o`=0.
  - all `link_io_reset_o`=1, all `link_core_reset_o`=1, all `link_token_reset_o`=0.
  - Links are held in reset until a sequence runs.
- `reset_i` mid-sequence: same as above on the next edge. The latched mask and counter are discarded.
- `reset_i` and `start_i` in the same cycle: reset wins; `start_i` is dropped.
- Cycle-level sequence, with `start_i` sampled at edge 0:
  - edge 1: state=ASSERT, `ready_o`=0, `done_o`=0; io=1 and core=1 on masked links.
  - edge 1+W: tkn=1.
  - edge 1+2W: tkn=0.
  - edge 1+3W: io=0.
  - edge 1+4W: core=0, `done_o`=1, `ready_o`=1.
- Restart from DONE: `start_i` at edge d gives `done_o`=0 at edge d+1 and a new ASSERT.
- Token-reset pulse width is exactly W cycles.
- io reset release precedes core reset release by exactly W cycles.
- Downstream synchronisation of io-side resets into the link io clock is the responsibility of the link; this block only guarantees dwell ≥ W core cycles.

## Test plan
- Reset, then idle 10 cycles:
  - All io/core resets stay at 1, all tkn at 0.
  - `ready_o`=1, `done_o`=0 throughout.
- start with mask=16'h0001, wait=3:
  - link0: io/core already 1 (stay 1); tkn rises at edge 4, falls at edge 7.
  - link0 io falls at edge 10; core falls and `done_o`=1 at edge 13.
  - Links 1–15 never change.
- wait=0 with mask=16'hFFFF:
  - Behaves as W=1.
  - tkn is high for 1 cycle at edge 2; `done_o` rises at edge 5.
- Second start with mask=16'h0002 after link0 is released:
  - link0 stays at io=0, core=0.
  - link1 sequences with the correct edges.
- `start_i` pulsed during TKN_ON with a different mask and wait:
  - Ignored.
  - Timing and mask of the original sequence are unchanged.
- `reset_i` asserted in IO_REL:
  - On the next edge, every link goes to io=1, core=1, tkn=0.
  - state IDLE, `done_o`=0.
  - A start in the same cycle as reset is dropped.
